// File: rtl/func_pkg.sv
// rtl/func_pkg.sv - shared widths, defaults, FSM state encoding and operand-pair type
package func_pkg;

    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 64;
    localparam int OP_W        = 8;
    localparam int RES_W       = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GUARD,
        ST_WAIT,
        ST_OUT
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } op_pair_t;

    function automatic op_pair_t make_pair(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        op_pair_t p;
        p.a = a;
        p.b = b;
        return p;
    endfunction

endpackage

// File: rtl/func_seq_if.sv
// rtl/func_seq_if.sv - operand ingress, compute-unit and result egress signal bundle
interface func_seq_if;
    import func_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [OP_W-1:0]  s_a;
    logic [OP_W-1:0]  s_b;

    logic [OP_W-1:0]  fn_a;
    logic [OP_W-1:0]  fn_b;
    logic             fn_start;
    logic             fn_done;
    logic [RES_W-1:0] fn_result;

    logic             m_valid;
    logic             m_ready;
    logic [RES_W-1:0] m_data;

    // sequencer side
    modport slave (
        input  s_valid, s_a, s_b, fn_done, fn_result, m_ready,
        output s_ready, fn_a, fn_b, fn_start, m_valid, m_data
    );

    // producer / compute unit / consumer side
    modport master (
        output s_valid, s_a, s_b, fn_done, fn_result, m_ready,
        input  s_ready, fn_a, fn_b, fn_start, m_valid, m_data
    );

endinterface

// File: rtl/op_fifo.sv
// rtl/op_fifo.sv - DEPTH-entry operand-pair FIFO with wrapping pointers and occupancy count
module op_fifo
    import func_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  op_pair_t         wdata,
    input  logic             pop,
    output op_pair_t         rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] level
);

    op_pair_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rdata   = mem[rd_ptr];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // storage needs no reset; validity is tracked by count
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/func_seq.sv
// rtl/func_seq.sv - sequences buffered operand pairs through an external compute unit one at a time
module func_seq
    import func_pkg::*;
#(
    parameter  int DEPTH   = DEF_DEPTH,
    parameter  int TIMEOUT = DEF_TIMEOUT,
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int TMR_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    func_seq_if.slave        bus,
    output logic [CNT_W-1:0] level_o,
    output logic             err_o
);

    state_t           state;
    logic [TMR_W-1:0] timer;
    logic [OP_W-1:0]  fn_a_q;
    logic [OP_W-1:0]  fn_b_q;
    logic             fn_start_q;
    logic             m_valid_q;
    logic [RES_W-1:0] m_data_q;
    logic             err_q;

    op_pair_t         head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    // ready is held low while reset is asserted
    assign bus.s_ready = rst_i && !full;
    assign push        = bus.s_valid && bus.s_ready;
    assign pop         = (state == ST_ISSUE);

    op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_i),
        .push  (push),
        .wdata (make_pair(bus.s_a, bus.s_b)),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    assign bus.fn_a     = fn_a_q;
    assign bus.fn_b     = fn_b_q;
    assign bus.fn_start = fn_start_q;
    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign err_o        = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ST_IDLE;
            timer      <= '0;
            fn_a_q     <= '0;
            fn_b_q     <= '0;
            fn_start_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            fn_start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        fn_a_q     <= head.a;
                        fn_b_q     <= head.b;
                        fn_start_q <= 1'b1;
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_GUARD;
                end
                // done may still be high from the previous op during this cycle
                ST_GUARD: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (bus.fn_done) begin
                        m_data_q  <= bus.fn_result;
                        m_valid_q <= 1'b1;
                        state     <= ST_OUT;
                    end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
